// File: rtl/board_ram_write_arbiter_if.sv
// rtl/board_ram_write_arbiter_if.sv - requester handshakes and RAM write port of the board RAM arbiter
interface board_ram_write_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 2
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [DATA_W-1:0] ram_wr_data;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, ram_we, ram_wr_addr, ram_wr_data
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, ram_we, ram_wr_addr, ram_wr_data
  );
endinterface

// File: rtl/board_ram_write_arbiter.sv
// rtl/board_ram_write_arbiter.sv - round-robin A/B write arbiter with full-board clear sequencer
module board_ram_write_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 2,
  parameter int CELLS  = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_req,
  output logic clear_busy,
  output logic clear_done,
  board_ram_write_arbiter_if.slave bus
);

  typedef enum logic [0:0] {IDLE, CLEAR} state_e;

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              last_b_q, last_b_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              arb_en, grant_a, grant_b;

  // A wins a tie only when B was served last.
  always_comb begin
    arb_en  = (state_q == IDLE) && !clear_req && !rst;
    grant_a = arb_en && bus.a_valid && (!bus.b_valid || last_b_q);
    grant_b = arb_en && bus.b_valid && !grant_a;
  end

  assign bus.a_ready   = grant_a;
  assign bus.b_ready   = grant_b;
  assign bus.ram_we      = we_q;
  assign bus.ram_wr_addr = addr_q;
  assign bus.ram_wr_data = data_q;
  assign clear_busy    = busy_q;
  assign clear_done    = done_q;

  // Address 0 is issued from IDLE so it reaches the RAM one cycle after clear_req;
  // cnt_q therefore holds the next clear address while in CLEAR.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_b_d = last_b_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          we_d    = 1'b1;
          addr_d  = '0;
          data_d  = '0;
          busy_d  = 1'b1;
          cnt_d   = ADDR_W'(1);
        end else if (grant_a) begin
          we_d     = 1'b1;
          addr_d   = bus.a_addr;
          data_d   = bus.a_data;
          last_b_d = 1'b0;
        end else if (grant_b) begin
          we_d     = 1'b1;
          addr_d   = bus.b_addr;
          data_d   = bus.b_data;
          last_b_d = 1'b1;
        end
      end
      CLEAR: begin
        we_d   = 1'b1;
        addr_d = cnt_q;
        data_d = '0;
        busy_d = 1'b1;
        cnt_d  = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_CELL) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_b_q <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_b_q <= last_b_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_board_ram_write_arbiter.sv
// tb/tb_board_ram_write_arbiter.sv - directed vector bench for board_ram_write_arbiter
module tb_board_ram_write_arbiter;

  typedef struct {
    int av, aa, ad, bv, ba, bd;
    int ar, br, we, wa, wd;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic clear_req;
  logic clear_busy;
  logic clear_done;
  logic preload;
  logic [1:0] mem [64];
  int n_chk  = 0;
  int n_fail = 0;
  vec_t vt [12];

  board_ram_write_arbiter_if #(.ADDR_W(6), .DATA_W(2)) bus ();

  board_ram_write_arbiter #(.ADDR_W(6), .DATA_W(2), .CELLS(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] pat(input int i);
    return i[0] ? 2'b10 : 2'b01;
  endfunction

  // Reference RAM: a write lands on the edge that samples ram_we.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= pat(i);
    end else if (bus.ram_we) begin
      mem[bus.ram_wr_addr] <= bus.ram_wr_data;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int av, input int aa, input int ad,
                       input int bv, input int ba, input int bd);
    bus.a_valid = av[0];
    bus.a_addr  = aa[5:0];
    bus.a_data  = ad[1:0];
    bus.b_valid = bv[0];
    bus.b_addr  = ba[5:0];
    bus.b_data  = bd[1:0];
  endtask

  initial begin
    bit found;
    //        av aa ad bv ba bd  ar br we wa wd
    vt[0]  = '{1, 18, 2, 1, 63, 2, 1, 0, 0, 0, 0};
    vt[1]  = '{1, 18, 2, 0, 0,  0, 1, 0, 1, 18, 2};
    vt[2]  = '{1, 7,  1, 1, 63, 2, 0, 1, 1, 18, 2};
    vt[3]  = '{1, 7,  1, 1, 63, 2, 1, 0, 1, 63, 2};
    vt[4]  = '{1, 7,  1, 1, 63, 2, 0, 1, 1, 7,  1};
    vt[5]  = '{1, 7,  1, 1, 63, 2, 1, 0, 1, 63, 2};
    vt[6]  = '{0, 0,  0, 0, 0,  0, 0, 0, 1, 7,  1};
    vt[7]  = '{0, 0,  0, 0, 0,  0, 0, 0, 0, 7,  1};
    vt[8]  = '{0, 0,  0, 1, 5,  1, 0, 1, 0, 7,  1};
    vt[9]  = '{1, 9,  2, 1, 10, 1, 1, 0, 1, 5,  1};
    vt[10] = '{0, 0,  0, 0, 0,  0, 0, 0, 1, 9,  2};
    vt[11] = '{0, 0,  0, 0, 0,  0, 0, 0, 0, 9,  2};

    rst = 1'b1;
    clear_req = 1'b0;
    preload = 1'b0;
    drive(1, 18, 2, 1, 63, 2);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_a_ready", bus.a_ready, 0);
      chk("rst_b_ready", bus.b_ready, 0);
      chk("rst_ram_we", bus.ram_we, 0);
      chk("rst_clear_busy", clear_busy, 0);
      chk("rst_ram_wr_addr", bus.ram_wr_addr, 0);
    end

    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      drive(vt[i].av, vt[i].aa, vt[i].ad, vt[i].bv, vt[i].ba, vt[i].bd);
      @(negedge clk);
      chk($sformatf("v%0d_a_ready", i), bus.a_ready, vt[i].ar);
      chk($sformatf("v%0d_b_ready", i), bus.b_ready, vt[i].br);
      chk($sformatf("v%0d_ram_we", i), bus.ram_we, vt[i].we);
      chk($sformatf("v%0d_ram_wr_addr", i), bus.ram_wr_addr, vt[i].wa);
      chk($sformatf("v%0d_ram_wr_data", i), bus.ram_wr_data, vt[i].wd);
    end
    chk("mem18_after_single", mem[18], 2);

    // Full clear with A requesting in the same cycle as clear_req.
    @(posedge clk); #1; preload = 1'b1;
    @(posedge clk); #1; preload = 1'b0;
    clear_req = 1'b1;
    drive(1, 33, 2, 0, 0, 0);
    @(negedge clk);
    chk("clrN_a_ready", bus.a_ready, 0);
    chk("clrN_busy", clear_busy, 0);
    @(posedge clk); #1; clear_req = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      if (k > 1) @(posedge clk);
      @(negedge clk);
      chk($sformatf("clr%0d_we", k), bus.ram_we, 1);
      chk($sformatf("clr%0d_addr", k), bus.ram_wr_addr, k - 1);
      chk($sformatf("clr%0d_data", k), bus.ram_wr_data, 0);
      chk($sformatf("clr%0d_busy", k), clear_busy, 1);
      chk($sformatf("clr%0d_done", k), clear_done, (k == 64) ? 1 : 0);
      chk($sformatf("clr%0d_a_ready", k), bus.a_ready, (k == 64) ? 1 : 0);
    end
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("clrA_we", bus.ram_we, 1);
    chk("clrA_addr", bus.ram_wr_addr, 33);
    chk("clrA_data", bus.ram_wr_data, 2);
    chk("clrA_busy", clear_busy, 0);
    chk("clrA_done", clear_done, 0);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 64; i++) chk($sformatf("clr_mem%0d", i), mem[i], (i == 33) ? 2 : 0);

    // Reset while clear address 20 is being issued.
    @(posedge clk); #1; preload = 1'b1;
    @(posedge clk); #1; preload = 1'b0; clear_req = 1'b1;
    @(posedge clk); #1; clear_req = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (bus.ram_we && bus.ram_wr_addr == 6'd19) found = 1'b1;
    end
    chk("rstclr_reached_addr19", found, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstclr_we", bus.ram_we, 0);
    chk("rstclr_busy", clear_busy, 0);
    chk("rstclr_addr", bus.ram_wr_addr, 0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rstclr_idle_we", bus.ram_we, 0);
    for (int i = 0; i < 64; i++)
      chk($sformatf("rstclr_mem%0d", i), mem[i], (i < 20) ? 0 : int'(pat(i)));

    // clear_req held high restarts on the first IDLE cycle.
    @(posedge clk); #1; clear_req = 1'b1;
    repeat (64) @(posedge clk);
    @(negedge clk);
    chk("hold_N64_done", clear_done, 1);
    chk("hold_N64_addr", bus.ram_wr_addr, 63);
    @(posedge clk);
    @(negedge clk);
    chk("hold_N65_we", bus.ram_we, 1);
    chk("hold_N65_addr", bus.ram_wr_addr, 0);
    chk("hold_N65_busy", clear_busy, 1);
    chk("hold_N65_done", clear_done, 0);
    clear_req = 1'b0;
    repeat (70) @(posedge clk);
    @(negedge clk);
    chk("hold_end_busy", clear_busy, 0);
    chk("hold_end_we", bus.ram_we, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
